// File: rtl/sram_d_arbiter_if.sv
// OBI-style data-port bundle shared by both requesters and the SRAM side.
//
// master modport: the side that issues requests (drives req/addr/we/be/wdata,
//                 receives gnt/rvalid/rdata/err).
// slave modport : the side that accepts requests (mirror of master).
//
// Signals:
//   req    request valid, held until gnt
//   gnt    request accepted this cycle
//   addr   byte address
//   we     write enable
//   be     byte enables
//   wdata  write data
//   rvalid response valid
//   rdata  read data
//   err    response error, qualified by rvalid
interface sram_d_arbiter_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/sram_d_arbiter.sv
// Two-master round-robin arbiter for the SRAM data-side OBI port.
// m0 is the core LSU, m1 the host/debug bridge. At most one request per cycle is forwarded to the
// SRAM; responses return in order and are routed by an ID FIFO. Requests outside
// [SRAM_BASE_ADDR, SRAM_END_ADDR) are answered locally with an error one cycle after acceptance.
//
// Ports:
//   clk_i      clock, all state on the rising edge
//   rst_i      asynchronous active-high reset; all outputs are 0 while asserted
//   m0_bus     master 0 request/response (slave side of the bundle)
//   m1_bus     master 1 request/response (slave side of the bundle)
//   s_bus      SRAM data port (master side of the bundle); s_bus.err is not used
//   illegal_o  one-cycle pulse when an out-of-range request is accepted
module sram_d_arbiter #(
  parameter logic [31:0] SRAM_BASE_ADDR  = 32'h8000_0000,
  parameter logic [31:0] SRAM_END_ADDR   = 32'h8000_C000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sram_d_arbiter_if.slave  m0_bus,
  sram_d_arbiter_if.slave  m1_bus,
  sram_d_arbiter_if.master s_bus,
  output logic             illegal_o
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);

  // StErrResp is the single cycle in which a local error response is returned.
  typedef enum logic [0:0] {StIdle, StErrResp} state_e;

  state_e state_q, state_d;

  logic [MAX_OUTSTANDING-1:0] id_mem_q;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       last_win_q, last_win_d;
  logic                       err_id_q, err_id_d;

  logic        fifo_full, fifo_empty, err_pend;
  logic        elig0, elig1, any_elig;
  logic        win_id;
  logic [31:0] win_addr, win_wdata;
  logic        win_we;
  logic [3:0]  win_be;
  logic        win_illegal;
  logic        fwd, accept_illegal, push, pop, win_gnt;
  logic        head_id;
  logic        unused_s_err;

  assign unused_s_err = s_bus.err;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  assign fifo_full  = (cnt_q == FullCnt);
  assign fifo_empty = (cnt_q == '0);
  assign err_pend   = (state_q == StErrResp);

  // A full FIFO blocks grants even when a pop happens in the same cycle.
  assign elig0    = m0_bus.req & ~fifo_full & ~err_pend & ~rst_i;
  assign elig1    = m1_bus.req & ~fifo_full & ~err_pend & ~rst_i;
  assign any_elig = elig0 | elig1;

  // On a tie the master that did not win last time goes next.
  assign win_id = (elig0 & elig1) ? ~last_win_q : elig1;

  assign win_addr  = win_id ? m1_bus.addr  : m0_bus.addr;
  assign win_we    = win_id ? m1_bus.we    : m0_bus.we;
  assign win_be    = win_id ? m1_bus.be    : m0_bus.be;
  assign win_wdata = win_id ? m1_bus.wdata : m0_bus.wdata;

  assign win_illegal = (win_addr < SRAM_BASE_ADDR) | (win_addr >= SRAM_END_ADDR);

  assign fwd = any_elig & ~win_illegal;
  // Illegal requests wait for the FIFO to drain so the error reply stays in order.
  assign accept_illegal = any_elig & win_illegal & fifo_empty;
  assign push    = fwd & s_bus.gnt;
  assign win_gnt = push | accept_illegal;

  // Stray responses with nothing outstanding are dropped here.
  assign pop     = s_bus.rvalid & ~fifo_empty;
  assign head_id = id_mem_q[rd_ptr_q];

  // --------------------------------------------------------------------------
  // Error-response FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Error-response FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept_illegal) state_d = StErrResp;
      StErrResp: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Error-response FSM: outputs (request path, grants and response routing)
  always_comb begin
    s_bus.req   = fwd;
    s_bus.addr  = fwd ? win_addr  : '0;
    s_bus.we    = fwd ? win_we    : 1'b0;
    s_bus.be    = fwd ? win_be    : '0;
    s_bus.wdata = fwd ? win_wdata : '0;

    m0_bus.gnt = win_gnt & ~win_id;
    m1_bus.gnt = win_gnt & win_id;
    illegal_o  = accept_illegal;

    m0_bus.rvalid = 1'b0;
    m0_bus.rdata  = '0;
    m0_bus.err    = 1'b0;
    m1_bus.rvalid = 1'b0;
    m1_bus.rdata  = '0;
    m1_bus.err    = 1'b0;

    case (state_q)
      StErrResp: begin
        // FIFO is necessarily empty here, so no SRAM response can collide.
        if (err_id_q) begin
          m1_bus.rvalid = 1'b1;
          m1_bus.err    = 1'b1;
        end else begin
          m0_bus.rvalid = 1'b1;
          m0_bus.err    = 1'b1;
        end
      end
      default: begin
        if (pop) begin
          if (head_id) begin
            m1_bus.rvalid = 1'b1;
            m1_bus.rdata  = s_bus.rdata;
          end else begin
            m0_bus.rvalid = 1'b1;
            m0_bus.rdata  = s_bus.rdata;
          end
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // ID FIFO and arbitration history
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_win_d = last_win_q;
    err_id_d   = err_id_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);

    if (win_gnt) begin
      last_win_d = win_id;
    end
    if (accept_illegal) begin
      err_id_d = win_id;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_mem_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      last_win_q <= 1'b1;
      err_id_q   <= 1'b0;
    end else begin
      if (push) begin
        id_mem_q[wr_ptr_q] <= win_id;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      last_win_q <= last_win_d;
      err_id_q   <= err_id_d;
    end
  end

endmodule

// File: tb/tb_sram_d_arbiter.sv
module tb_sram_d_arbiter;
  localparam int unsigned MaxOut = 2;
  localparam logic [31:0] Base = 32'h8000_0000;
  localparam logic [31:0] End  = 32'h8000_C000;

  logic clk_i = 1'b0;
  logic rst_i;
  logic illegal_o;

  always #5 clk_i = ~clk_i;

  sram_d_arbiter_if m0_bus ();
  sram_d_arbiter_if m1_bus ();
  sram_d_arbiter_if s_bus ();

  sram_d_arbiter #(
    .SRAM_BASE_ADDR (Base),
    .SRAM_END_ADDR  (End),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m0_bus   (m0_bus),
    .m1_bus   (m1_bus),
    .s_bus    (s_bus),
    .illegal_o(illegal_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: ordered list of owners of outstanding SRAM transactions.
  bit id_q[$];
  bit m_last     = 1'b1;
  bit m_err_pend = 1'b0;
  bit m_err_who  = 1'b0;

  // Expected outputs and events for the current cycle.
  bit          e_gnt[2];
  bit          e_rv[2];
  bit          e_err[2];
  logic [31:0] e_rdata[2];
  bit          e_sreq, e_ill;
  logic [68:0] e_sattr;
  bit          ev_push, ev_pop, ev_err, ev_who;

  // Random-master and SRAM stimulus state.
  bit          mp[2];
  logic [31:0] ma[2], mwd[2];
  bit          mwe[2];
  logic [3:0]  mbe[2];
  int          sram_pend = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_m(input int i, input bit req, input logic [31:0] addr, input bit we,
                       input logic [3:0] be, input logic [31:0] wd);
    if (i == 0) begin
      m0_bus.req = req; m0_bus.addr = addr; m0_bus.we = we; m0_bus.be = be; m0_bus.wdata = wd;
    end else begin
      m1_bus.req = req; m1_bus.addr = addr; m1_bus.we = we; m1_bus.be = be; m1_bus.wdata = wd;
    end
  endtask

  task automatic idle();
    set_m(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_m(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    s_bus.gnt = 1'b0; s_bus.rvalid = 1'b0; s_bus.rdata = 32'h0; s_bus.err = 1'b0;
  endtask

  task automatic model_eval();
    bit          w;
    logic [31:0] a;
    e_gnt = '{0, 0}; e_rv = '{0, 0}; e_err = '{0, 0}; e_rdata = '{32'h0, 32'h0};
    e_sreq = 0; e_ill = 0; e_sattr = '0;
    ev_push = 0; ev_pop = 0; ev_err = 0; ev_who = 0;
    if (rst_i) begin
      id_q.delete();
      m_last = 1'b1;
      m_err_pend = 1'b0;
    end else begin
      if (!m_err_pend && id_q.size() < MaxOut && (m0_bus.req || m1_bus.req)) begin
        w = (m0_bus.req && m1_bus.req) ? !m_last : m1_bus.req;
        a = w ? m1_bus.addr : m0_bus.addr;
        if (a >= Base && a < End) begin
          e_sreq  = 1;
          e_sattr = w ? {m1_bus.addr, m1_bus.we, m1_bus.be, m1_bus.wdata}
                      : {m0_bus.addr, m0_bus.we, m0_bus.be, m0_bus.wdata};
          e_gnt[w] = s_bus.gnt;
          ev_push  = s_bus.gnt;
        end else if (id_q.size() == 0) begin
          e_gnt[w] = 1;
          e_ill    = 1;
          ev_err   = 1;
        end
        ev_who = w;
      end
      if (m_err_pend) begin
        e_rv[m_err_who]  = 1;
        e_err[m_err_who] = 1;
      end else if (s_bus.rvalid && id_q.size() != 0) begin
        e_rv[id_q[0]]    = 1;
        e_rdata[id_q[0]] = s_bus.rdata;
        ev_pop = 1;
      end
    end
  endtask

  task automatic model_update();
    if (!rst_i) begin
      if (ev_pop) void'(id_q.pop_front());
      if (ev_push) id_q.push_back(ev_who);
      if (e_gnt[0] || e_gnt[1]) m_last = ev_who;
      m_err_pend = ev_err;
      if (ev_err) m_err_who = ev_who;
    end
  endtask

  // Called at the falling edge after inputs are driven.
  task automatic eval_and_check();
    #1;
    model_eval();
    check("m_gnt", {m0_bus.gnt, m1_bus.gnt}, {e_gnt[0], e_gnt[1]});
    check("m_rvalid", {m0_bus.rvalid, m1_bus.rvalid}, {e_rv[0], e_rv[1]});
    check("illegal", illegal_o, e_ill);
    check("s_req", s_bus.req, e_sreq);
    if (e_sreq) check("s_attr", {s_bus.addr, s_bus.we, s_bus.be, s_bus.wdata}, e_sattr);
    if (e_rv[0]) check("m0_rsp", {m0_bus.err, m0_bus.rdata}, {e_err[0], e_rdata[0]});
    if (e_rv[1]) check("m1_rsp", {m1_bus.err, m1_bus.rdata}, {e_err[1], e_rdata[1]});
    if (rst_i) begin
      check("rst_sattr", {s_bus.addr, s_bus.we, s_bus.be, s_bus.wdata}, '0);
      check("rst_rsp", {m0_bus.rdata, m0_bus.err, m1_bus.rdata, m1_bus.err}, '0);
    end
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    eval_and_check();
    advance();
    rst_i = 1'b0;
    sram_pend = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return Base - 32'd4;
      1:       return End;
      2:       return End - 32'd4;
      3:       return Base;
      4:       return $urandom;
      default: return Base + {18'h0, 12'($urandom_range(0, 12'hBFF)), 2'b00};
    endcase
  endfunction

  initial begin
    idle();
    rst_i = 1'b1;
    @(negedge clk_i);

    // 1: single legal read, one-cycle SRAM latency.
    do_reset();
    set_m(0, 1'b1, 32'h8000_0010, 1'b0, 4'hF, 32'h0);
    s_bus.gnt = 1'b1;
    eval_and_check();
    check("t1_gnt", m0_bus.gnt, 1'b1);
    check("t1_saddr", s_bus.addr, 32'h8000_0010);
    advance();
    idle();
    s_bus.rvalid = 1'b1; s_bus.rdata = 32'h1234_5678;
    eval_and_check();
    check("t1_rvalid_err", {m0_bus.rvalid, m0_bus.err}, 2'b10);
    check("t1_rdata", m0_bus.rdata, 32'h1234_5678);
    advance();

    // 2: both masters contend every cycle; grants alternate starting with m0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_m(0, 1'b1, 32'h8000_0100, 1'b0, 4'hF, 32'h0);
      set_m(1, 1'b1, 32'h8000_0200, 1'b1, 4'h3, 32'hA5A5_0000 + 32'(i));
      s_bus.gnt = 1'b1; s_bus.rvalid = (i > 0); s_bus.rdata = 32'h100 + 32'(i);
      eval_and_check();
      check("t2_gnt", {m0_bus.gnt, m1_bus.gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) check("t2_route", {m0_bus.rvalid, m1_bus.rvalid}, (i % 2 == 1) ? 2'b10 : 2'b01);
      advance();
    end
    idle();
    s_bus.rvalid = 1'b1; s_bus.rdata = 32'hBEEF;
    eval_and_check();
    check("t2_last_route", {m0_bus.rvalid, m1_bus.rvalid, m1_bus.rdata}, {2'b01, 32'hBEEF});
    advance();

    // 3: out-of-range request from m1 answered locally.
    do_reset();
    set_m(1, 1'b1, 32'h8000_C000, 1'b0, 4'hF, 32'h0);
    s_bus.gnt = 1'b1;
    eval_and_check();
    check("t3_accept", {m1_bus.gnt, illegal_o, s_bus.req}, 3'b110);
    advance();
    idle();
    eval_and_check();
    check("t3_err_rsp", {m1_bus.rvalid, m1_bus.err, m1_bus.rdata, m0_bus.rvalid}, {2'b11, 32'h0, 1'b0});
    advance();

    // 4: FIFO full blocks the third grant, including in the cycle of the first pop.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_m(0, 1'b1, 32'h8000_0040, 1'b0, 4'hF, 32'h0);
      s_bus.gnt = 1'b1; s_bus.rvalid = (i == 3); s_bus.rdata = 32'h4444;
      eval_and_check();
      check("t4_gnt", m0_bus.gnt, (i == 2 || i == 3) ? 1'b0 : 1'b1);
      advance();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'h4445 + 32'(i);
      eval_and_check();
      advance();
    end

    // 5: SRAM stalls for three cycles; request and attributes are held.
    do_reset();
    set_m(0, 1'b1, 32'h8000_0100, 1'b1, 4'b0011, 32'hCAFE_BABE);
    for (int i = 0; i < 3; i++) begin
      eval_and_check();
      check("t5_hold", {s_bus.req, m0_bus.gnt, s_bus.addr, s_bus.wdata},
            {2'b10, 32'h8000_0100, 32'hCAFE_BABE});
      advance();
    end
    s_bus.gnt = 1'b1;
    eval_and_check();
    check("t5_gnt", m0_bus.gnt, 1'b1);
    advance();
    idle();
    s_bus.rvalid = 1'b1;
    eval_and_check();
    advance();

    // 6: reset with one transaction outstanding; late response is dropped.
    do_reset();
    set_m(0, 1'b1, 32'h8000_0020, 1'b0, 4'hF, 32'h0);
    s_bus.gnt = 1'b1;
    eval_and_check();
    advance();
    idle();
    rst_i = 1'b1;
    eval_and_check();
    advance();
    rst_i = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rdata = 32'hDEAD_DEAD;
    eval_and_check();
    check("t6_stray", {m0_bus.rvalid, m1_bus.rvalid}, 2'b00);
    advance();
    set_m(0, 1'b1, 32'h8000_0030, 1'b0, 4'hF, 32'h0);
    set_m(1, 1'b1, 32'h8000_0034, 1'b0, 4'hF, 32'h0);
    s_bus.gnt = 1'b1; s_bus.rvalid = 1'b0;
    eval_and_check();
    check("t6_m0_first", {m0_bus.gnt, m1_bus.gnt}, 2'b10);
    advance();
    idle();
    s_bus.rvalid = 1'b1;
    eval_and_check();
    advance();

    // Randomized traffic with occasional resets.
    do_reset();
    mp = '{0, 0};
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mp[i] && $urandom_range(0, 2) != 0) begin
          mp[i] = 1; ma[i] = rand_addr(); mwe[i] = 1'($urandom);
          mbe[i] = 4'($urandom); mwd[i] = $urandom;
        end
        set_m(i, mp[i], ma[i], mwe[i], mbe[i], mwd[i]);
      end
      rst_i = ($urandom_range(0, 299) == 0);
      s_bus.gnt = ($urandom_range(0, 3) != 0);
      s_bus.rvalid = (sram_pend > 0) && ($urandom_range(0, 1) == 1);
      s_bus.rdata = $urandom;
      eval_and_check();
      advance();
      if (rst_i) begin
        sram_pend = 0;
      end else begin
        sram_pend = sram_pend + int'(ev_push) - int'(s_bus.rvalid);
      end
      for (int i = 0; i < 2; i++) if (e_gnt[i]) mp[i] = 0;
    end
    rst_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
